// File: rtl/mdu_ctrl_pkg.sv
// Shared constants and helpers for the multiply/divide unit.
// Operation encodings, controller states and opcode classifiers.
package mdu_ctrl_pkg;

  localparam logic [3:0] MDU_NONE  = 4'd0;
  localparam logic [3:0] MDU_MULT  = 4'd1;
  localparam logic [3:0] MDU_MULTU = 4'd2;
  localparam logic [3:0] MDU_DIV   = 4'd3;
  localparam logic [3:0] MDU_DIVU  = 4'd4;
  localparam logic [3:0] MDU_MTHI  = 4'd5;
  localparam logic [3:0] MDU_MTLO  = 4'd6;
  localparam logic [3:0] MDU_MFHI  = 4'd7;
  localparam logic [3:0] MDU_MFLO  = 4'd8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mdu_state_t;

  function automatic logic is_start(input logic [3:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) ||
           (op == MDU_DIV)  || (op == MDU_DIVU);
  endfunction

  function automatic logic is_mult(input logic [3:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU);
  endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// E-stage issue bundle and HI/LO result bundle of the MDU.
// The pipeline drives as master; the controller is the slave.
interface mdu_ctrl_if;
  import mdu_ctrl_pkg::*;

  logic [3:0]  E_MDUOp;
  logic [31:0] E_A;
  logic [31:0] E_B;
  logic        Req;
  logic        Start;
  logic        Busy;
  logic        MDUing;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] E_MDUOut;

  modport master (
    output E_MDUOp, E_A, E_B, Req,
    input  Start, Busy, MDUing, HI, LO, E_MDUOut
  );

  modport slave (
    input  E_MDUOp, E_A, E_B, Req,
    output Start, Busy, MDUing, HI, LO, E_MDUOut
  );

endinterface

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath for the latched operation.
// valid is low for non-arith ops and for division by zero.
module mdu_arith
  import mdu_ctrl_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        valid
);

  logic [63:0]        sprod;
  logic [63:0]        uprod;
  logic signed [31:0] sq;
  logic signed [31:0] sr;
  logic [31:0]        uq;
  logic [31:0]        ur;

  // Low 64 bits of the extended product equal the true signed product.
  assign sprod = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign uprod = {32'd0, a} * {32'd0, b};
  assign sq    = $signed(a) / $signed(b);
  assign sr    = $signed(a) % $signed(b);
  assign uq    = a / b;
  assign ur    = a % b;

  always_comb begin
    hi    = '0;
    lo    = '0;
    valid = 1'b0;
    unique case (1'b1)
      (op == MDU_MULT): begin
        {hi, lo} = sprod;
        valid    = 1'b1;
      end
      (op == MDU_MULTU): begin
        {hi, lo} = uprod;
        valid    = 1'b1;
      end
      (op == MDU_DIV): begin
        hi    = sr;
        lo    = sq;
        valid = (b != 32'd0);
      end
      (op == MDU_DIVU): begin
        hi    = ur;
        lo    = uq;
        valid = (b != 32'd0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle MDU controller: issue, busy countdown, HI/LO commit.
// Move-to ops write immediately; arith ops commit after N cycles.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  mdu_ctrl_if.slave  bus
);

  localparam int CW = $clog2(DIV_CYCLES + 1);
  localparam logic [CW-1:0] MULT_N = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_N  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] ONE    = CW'(1);

  mdu_state_t  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        start;
  logic        busy;
  logic [31:0] n_hi;
  logic [31:0] n_lo;
  logic        n_valid;

  assign start = is_start(bus.E_MDUOp) && !bus.Req && !reset;
  assign busy  = (state_q == BUSY);

  assign bus.Start  = start;
  assign bus.Busy   = busy;
  assign bus.MDUing = start | (busy & ~reset);
  assign bus.HI     = hi_q;
  assign bus.LO     = lo_q;

  mdu_arith u_arith (
    .op    (op_q),
    .a     (a_q),
    .b     (b_q),
    .hi    (n_hi),
    .lo    (n_lo),
    .valid (n_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= MDU_NONE;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          op_d    = bus.E_MDUOp;
          a_d     = bus.E_A;
          b_d     = bus.E_B;
          cnt_d   = is_mult(bus.E_MDUOp) ? MULT_N : DIV_N;
          state_d = BUSY;
        end else if (!bus.Req) begin
          if (bus.E_MDUOp == MDU_MTHI) hi_d = bus.E_A;
          if (bus.E_MDUOp == MDU_MTLO) lo_d = bus.E_A;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - ONE;
        // Commit on the 1->0 step; a zero divisor leaves HI/LO intact.
        if (cnt_q == ONE) begin
          state_d = IDLE;
          if (n_valid) begin
            hi_d = n_hi;
            lo_d = n_lo;
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    bus.E_MDUOut = '0;
    unique case (1'b1)
      (bus.E_MDUOp == MDU_MFHI): bus.E_MDUOut = hi_q;
      (bus.E_MDUOp == MDU_MFLO): bus.E_MDUOut = lo_q;
      default: ;
    endcase
  end

  a_no_issue_while_busy: assert property (
    @(posedge clk) disable iff (reset)
    !(busy && !bus.Req &&
      (is_start(bus.E_MDUOp) ||
       bus.E_MDUOp == MDU_MTHI ||
       bus.E_MDUOp == MDU_MTLO))
  );

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed plus randomized bench for mdu_ctrl.
// Reference model tracks HI/LO with plain 64-bit arithmetic.
module tb_mdu_ctrl;
  import mdu_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mdu_ctrl_if bus();

  mdu_ctrl #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic model(input logic [3:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b);
    longint sa, sb, p, q, r;
    logic [63:0] up, ua, ub, uq, ur;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      MDU_MULT: begin
        p = sa * sb;
        m_hi = p[63:32];
        m_lo = p[31:0];
      end
      MDU_MULTU: begin
        up = ua * ub;
        m_hi = up[63:32];
        m_lo = up[31:0];
      end
      MDU_DIV: if (b != 0) begin
        q = sa / sb;
        r = sa % sb;
        m_lo = q[31:0];
        m_hi = r[31:0];
      end
      MDU_DIVU: if (b != 0) begin
        uq = ua / ub;
        ur = ua % ub;
        m_lo = uq[31:0];
        m_hi = ur[31:0];
      end
      MDU_MTHI: m_hi = a;
      MDU_MTLO: m_lo = a;
      default: ;
    endcase
  endtask

  task automatic issue(input string tag,
                       input logic [3:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b);
    int n;
    int want;
    logic st;
    st = (op == MDU_MULT) || (op == MDU_MULTU) ||
         (op == MDU_DIV) || (op == MDU_DIVU);
    want = ((op == MDU_MULT) || (op == MDU_MULTU)) ? 5 : 10;
    bus.E_MDUOp = op;
    bus.E_A = a;
    bus.E_B = b;
    bus.Req = 1'b0;
    #1;
    chk({tag, "_start"}, 32'(bus.Start), 32'(st));
    chk({tag, "_mduing"}, 32'(bus.MDUing), 32'(st));
    step();
    bus.E_MDUOp = MDU_NONE;
    n = 0;
    while (bus.Busy && n < 40) begin
      n++;
      step();
    end
    chk({tag, "_busycyc"}, 32'(n), st ? 32'(want) : 32'd0);
    model(op, a, b);
    chk({tag, "_hi"}, bus.HI, m_hi);
    chk({tag, "_lo"}, bus.LO, m_lo);
  endtask

  initial begin
    int n;
    logic [3:0] ops [6];
    logic [3:0] op;
    logic [31:0] a, b;
    ops[0] = MDU_MULT;
    ops[1] = MDU_MULTU;
    ops[2] = MDU_DIV;
    ops[3] = MDU_DIVU;
    ops[4] = MDU_MTHI;
    ops[5] = MDU_MTLO;

    reset = 1'b1;
    bus.E_MDUOp = MDU_MULT;
    bus.E_A = 32'd5;
    bus.E_B = 32'd6;
    bus.Req = 1'b0;
    #1;
    chk("rst_start", 32'(bus.Start), 32'd0);
    chk("rst_mduing", 32'(bus.MDUing), 32'd0);
    step();
    step();
    bus.E_MDUOp = MDU_NONE;
    reset = 1'b0;
    chk("rst_busy", 32'(bus.Busy), 32'd0);
    chk("rst_hi", bus.HI, 32'd0);
    chk("rst_lo", bus.LO, 32'd0);

    issue("mult_neg", MDU_MULT, 32'hFFFF_FFFE, 32'd3);
    chk("mult_neg_hi_k", bus.HI, 32'hFFFF_FFFF);
    chk("mult_neg_lo_k", bus.LO, 32'hFFFF_FFFA);

    issue("div_neg", MDU_DIV, -32'sd7, 32'd2);
    chk("div_neg_lo_k", bus.LO, 32'hFFFF_FFFD);
    chk("div_neg_hi_k", bus.HI, 32'hFFFF_FFFF);

    issue("divu", MDU_DIVU, 32'd7, 32'd2);
    chk("divu_lo_k", bus.LO, 32'd3);
    chk("divu_hi_k", bus.HI, 32'd1);

    issue("mthi", MDU_MTHI, 32'h11, 32'd0);
    issue("mtlo", MDU_MTLO, 32'h22, 32'd0);
    issue("divu0", MDU_DIVU, 32'd99, 32'd0);
    chk("divu0_hi_k", bus.HI, 32'h11);
    chk("divu0_lo_k", bus.LO, 32'h22);

    bus.E_MDUOp = MDU_MULT;
    bus.E_A = 32'd1234;
    bus.E_B = 32'd5678;
    bus.Req = 1'b1;
    #1;
    chk("req_start", 32'(bus.Start), 32'd0);
    chk("req_mduing", 32'(bus.MDUing), 32'd0);
    step();
    chk("req_busy", 32'(bus.Busy), 32'd0);
    bus.E_MDUOp = MDU_MTHI;
    step();
    bus.E_MDUOp = MDU_NONE;
    bus.Req = 1'b0;
    step();
    chk("req_hi", bus.HI, m_hi);
    chk("req_lo", bus.LO, m_lo);

    bus.E_MDUOp = MDU_MULT;
    bus.E_A = 32'd1000;
    bus.E_B = 32'hFFFF_FFF0;
    step();
    bus.E_MDUOp = MDU_NONE;
    n = 0;
    while (bus.Busy && n < 40) begin
      n++;
      bus.Req = (n == 2);
      step();
    end
    bus.Req = 1'b0;
    chk("reqbusy_cyc", 32'(n), 32'd5);
    model(MDU_MULT, 32'd1000, 32'hFFFF_FFF0);
    chk("reqbusy_hi", bus.HI, m_hi);
    chk("reqbusy_lo", bus.LO, m_lo);

    issue("pre_rst", MDU_MTHI, 32'h5555, 32'd0);
    bus.E_MDUOp = MDU_DIV;
    bus.E_A = 32'd1000;
    bus.E_B = 32'd7;
    step();
    bus.E_MDUOp = MDU_NONE;
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    m_hi = '0;
    m_lo = '0;
    chk("abort_busy", 32'(bus.Busy), 32'd0);
    chk("abort_hi", bus.HI, 32'd0);
    chk("abort_lo", bus.LO, 32'd0);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.Busy) n++;
      step();
    end
    chk("abort_nobusy", 32'(n), 32'd0);
    chk("abort_hi_late", bus.HI, 32'd0);
    chk("abort_lo_late", bus.LO, 32'd0);

    issue("mtlo_fwd", MDU_MTLO, 32'hABCD, 32'd0);
    bus.E_MDUOp = MDU_MFLO;
    #1;
    chk("mflo_out", bus.E_MDUOut, 32'hABCD);
    chk("mflo_mduing", 32'(bus.MDUing), 32'd0);
    bus.E_MDUOp = MDU_MFHI;
    #1;
    chk("mfhi_out", bus.E_MDUOut, m_hi);
    step();
    bus.E_MDUOp = MDU_NONE;

    for (int i = 0; i < 24; i++) begin
      op = ops[$urandom_range(0, 5)];
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 2) == 0) b = $urandom_range(1, 40);
      if ($urandom_range(0, 6) == 0) b = 32'd0;
      if (op == MDU_DIV && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
        b = 32'd3;
      issue($sformatf("rnd%0d", i), op, a, b);
      bus.E_MDUOp = MDU_MFHI;
      #1;
      chk($sformatf("rnd%0d_mfhi", i), bus.E_MDUOut, m_hi);
      bus.E_MDUOp = MDU_MFLO;
      #1;
      chk($sformatf("rnd%0d_mflo", i), bus.E_MDUOut, m_lo);
      bus.E_MDUOp = MDU_NONE;
      #1;
      chk($sformatf("rnd%0d_none", i), bus.E_MDUOut, 32'd0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
